// File: rtl/bip_pkg.sv
// Shared encodings for the 16-bit accumulator processor control unit:
// opcodes, FSM states, instruction classes and datapath mux/op settings.
package bip_pkg;

    localparam int BIP_DB    = 16;
    localparam int BIP_PC_W  = 11;
    localparam int BIP_OPC_W = 5;

    localparam logic [BIP_OPC_W-1:0] OPC_HLT  = 5'b00000;
    localparam logic [BIP_OPC_W-1:0] OPC_STO  = 5'b00001;
    localparam logic [BIP_OPC_W-1:0] OPC_LD   = 5'b00010;
    localparam logic [BIP_OPC_W-1:0] OPC_LDI  = 5'b00011;
    localparam logic [BIP_OPC_W-1:0] OPC_ADD  = 5'b00100;
    localparam logic [BIP_OPC_W-1:0] OPC_ADDI = 5'b00101;
    localparam logic [BIP_OPC_W-1:0] OPC_SUB  = 5'b00110;
    localparam logic [BIP_OPC_W-1:0] OPC_SUBI = 5'b00111;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC_A = 3'd3,
        S_EXEC_B = 3'd4,
        S_STORE  = 3'd5,
        S_NEXT   = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_MEM   = 3'd0,
        CLS_IMM   = 3'd1,
        CLS_STORE = 3'd2,
        CLS_HALT  = 3'd3,
        CLS_NOP   = 3'd4
    } instr_cls_t;

    typedef enum logic [1:0] {
        SELA_RAM = 2'b00,
        SELA_IMM = 2'b01,
        SELA_ALU = 2'b10
    } sel_a_t;

    localparam logic SELB_RAM = 1'b0;
    localparam logic SELB_IMM = 1'b1;
    localparam logic OP_ADD   = 1'b0;
    localparam logic OP_SUB   = 1'b1;

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode decoder: instruction class plus ACC/ALU mux and op
// settings for the instruction currently held in IR.
module bip_decoder
    import bip_pkg::*;
(
    input  logic [BIP_OPC_W-1:0] i_opcode,
    output instr_cls_t           o_cls,
    output sel_a_t               o_sel_a,
    output logic                 o_sel_b,
    output logic                 o_op
);

    always_comb begin
        o_cls   = CLS_NOP;
        o_sel_a = SELA_RAM;
        o_sel_b = SELB_RAM;
        o_op    = OP_ADD;
        case (i_opcode)
            OPC_HLT:  o_cls = CLS_HALT;
            OPC_STO:  o_cls = CLS_STORE;
            OPC_LD:   o_cls = CLS_MEM;
            OPC_LDI: begin
                o_cls   = CLS_IMM;
                o_sel_a = SELA_IMM;
            end
            OPC_ADD: begin
                o_cls   = CLS_MEM;
                o_sel_a = SELA_ALU;
            end
            OPC_ADDI: begin
                o_cls   = CLS_IMM;
                o_sel_a = SELA_ALU;
                o_sel_b = SELB_IMM;
            end
            OPC_SUB: begin
                o_cls   = CLS_MEM;
                o_sel_a = SELA_ALU;
                o_op    = OP_SUB;
            end
            OPC_SUBI: begin
                o_cls   = CLS_IMM;
                o_sel_a = SELA_ALU;
                o_sel_b = SELB_IMM;
                o_op    = OP_SUB;
            end
            default: o_cls = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/bip_control_unit.sv
// Multi-cycle control unit: fetches from program memory, owns PC/IR and the
// retired-instruction counter, and sequences the datapath one instruction at a time.
module bip_control_unit
    import bip_pkg::*;
#(
    parameter int DB    = BIP_DB,
    parameter int PC_W  = BIP_PC_W,
    parameter int OPC_W = BIP_OPC_W
) (
    input  logic            clk,
    input  logic            Reset,
    input  logic            Enable,
    input  logic [DB-1:0]   Instr,
    output logic [PC_W-1:0] PC,
    output logic [PC_W-1:0] Operand,
    output logic            WrPC,
    output logic [1:0]      SelA,
    output logic            SelB,
    output logic            Op,
    output logic            WrAcc,
    output logic            Clear,
    output logic            RdRam,
    output logic            WrRam,
    output logic            Halted,
    output logic [15:0]     InstrCnt
);

    state_t          r_state;
    state_t          w_next;
    logic [DB-1:0]   r_ir;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_icnt;

    instr_cls_t      w_cls;
    sel_a_t          w_sel_a;
    logic            w_sel_b;
    logic            w_op;
    logic            w_mem;

    bip_decoder u_dec (
        .i_opcode (r_ir[DB-1 -: OPC_W]),
        .o_cls    (w_cls),
        .o_sel_a  (w_sel_a),
        .o_sel_b  (w_sel_b),
        .o_op     (w_op)
    );

    assign w_mem    = (w_cls == CLS_MEM);
    assign PC       = r_pc;
    assign Operand  = r_ir[PC_W-1:0];
    assign InstrCnt = r_icnt;

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state <= S_INIT;
            r_ir    <= '0;
            r_pc    <= '0;
            r_icnt  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_INIT:  r_pc <= '0;
                S_FETCH: if (Enable) r_ir <= Instr;
                S_NEXT: begin
                    r_pc   <= r_pc + 1'b1;
                    r_icnt <= r_icnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        WrPC   = 1'b0;
        SelA   = SELA_RAM;
        SelB   = SELB_RAM;
        Op     = OP_ADD;
        WrAcc  = 1'b0;
        Clear  = 1'b0;
        RdRam  = 1'b0;
        WrRam  = 1'b0;
        Halted = 1'b0;
        case (r_state)
            S_INIT: begin
                // INIT is also the hold state under reset; keep Clear quiet until release
                Clear  = !Reset;
                w_next = S_FETCH;
            end
            S_FETCH: if (Enable) w_next = S_DECODE;
            S_DECODE: begin
                RdRam = w_mem;
                case (w_cls)
                    CLS_HALT:  w_next = S_HALT;
                    CLS_NOP:   w_next = S_NEXT;
                    CLS_STORE: w_next = S_STORE;
                    default:   w_next = S_EXEC_A;
                endcase
            end
            S_EXEC_A, S_EXEC_B: begin
                WrAcc  = 1'b1;
                SelA   = w_sel_a;
                SelB   = w_sel_b;
                Op     = w_op;
                RdRam  = w_mem;
                w_next = (r_state == S_EXEC_A) ? S_EXEC_B : S_NEXT;
            end
            S_STORE: begin
                WrRam  = 1'b1;
                w_next = S_NEXT;
            end
            S_NEXT: begin
                WrPC   = 1'b1;
                w_next = S_FETCH;
            end
            S_HALT:  Halted = 1'b1;
            default: w_next = S_INIT;
        endcase
    end

endmodule

// File: tb/tb_bip_control_unit.sv
// Directed bench for bip_control_unit: a vector table of single instructions
// plus hand-written reset, stall, halt, PC-wrap and mid-execute reset sequences.
module tb_bip_control_unit;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Enable = 1'b1;
    logic [15:0] Instr = '0;
    logic [10:0] PC;
    logic [10:0] Operand;
    logic        WrPC;
    logic [1:0]  SelA;
    logic        SelB;
    logic        Op;
    logic        WrAcc;
    logic        Clear;
    logic        RdRam;
    logic        WrRam;
    logic        Halted;
    logic [15:0] InstrCnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bip_control_unit #(.DB(16), .PC_W(11), .OPC_W(5)) dut (
        .clk(clk), .Reset(Reset), .Enable(Enable), .Instr(Instr),
        .PC(PC), .Operand(Operand), .WrPC(WrPC), .SelA(SelA), .SelB(SelB),
        .Op(Op), .WrAcc(WrAcc), .Clear(Clear), .RdRam(RdRam), .WrRam(WrRam),
        .Halted(Halted), .InstrCnt(InstrCnt)
    );

    typedef struct {
        logic [15:0] instr;
        int          cyc;
        int          rd;
        int          acc;
        int          ram;
        logic [1:0]  sela;
        logic        selb;
        logic        op;
    } vec_t;

    vec_t tbl[9];

    // per-instruction observations
    int          res_cyc, res_rd, res_acc, res_ram, res_run_max, res_bad_idle;
    int          res_wrpc, res_clear;
    logic [1:0]  res_sela;
    logic        res_selb, res_op, res_halt;
    logic [10:0] res_opnd;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called while the DUT is in FETCH; returns at the next FETCH (or after HALT is seen).
    task automatic run_instr(input logic [15:0] instr);
        int run;
        bit done;
        Instr = instr;
        res_cyc = 0; res_rd = 0; res_acc = 0; res_ram = 0; res_run_max = 0;
        res_bad_idle = 0; res_wrpc = 0; res_clear = 0; res_halt = 1'b0;
        res_sela = 2'b00; res_selb = 1'b0; res_op = 1'b0; res_opnd = '0;
        run = 0;
        done = 1'b0;
        while (!done && res_cyc < 20) begin
            res_cyc++;
            res_rd    += int'(RdRam);
            res_ram   += int'(WrRam);
            res_clear += int'(Clear);
            if (WrAcc) begin
                res_acc++;
                run++;
                if (run > res_run_max) res_run_max = run;
                res_sela = SelA;
                res_selb = SelB;
                res_op   = Op;
            end else begin
                run = 0;
                if (SelA != 2'b00 || SelB || Op) res_bad_idle++;
            end
            if (WrPC) begin
                res_wrpc++;
                res_opnd = Operand;
                done = 1'b1;
            end
            if (Halted) begin
                res_halt = 1'b1;
                res_opnd = Operand;
                done = 1'b1;
            end
            step();
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Enable = 1'b1;
        repeat (2) step();
        chk("rst_pc", int'(PC), 0);
        chk("rst_cnt", int'(InstrCnt), 0);
        chk("rst_operand", int'(Operand), 0);
        chk("rst_strobes", int'({WrPC, WrAcc, Clear, RdRam, WrRam, Halted}), 0);
        chk("rst_sel", int'({SelA, SelB, Op}), 0);
        Reset = 1'b0;
        #1;
        chk("init_clear", int'(Clear), 1);
        step();
        chk("fetch_clear_low", int'(Clear), 0);
    endtask

    task automatic check_vec(input int i, input vec_t v, input int pc0);
        chk($sformatf("v%0d_cycles", i), res_cyc, v.cyc);
        chk($sformatf("v%0d_rdram", i), res_rd, v.rd);
        chk($sformatf("v%0d_wracc", i), res_acc, v.acc);
        chk($sformatf("v%0d_wracc_run", i), res_run_max, v.acc);
        chk($sformatf("v%0d_wrram", i), res_ram, v.ram);
        chk($sformatf("v%0d_sela", i), int'(res_sela), int'(v.sela));
        chk($sformatf("v%0d_selb", i), int'(res_selb), int'(v.selb));
        chk($sformatf("v%0d_op", i), int'(res_op), int'(v.op));
        chk($sformatf("v%0d_idle_sel", i), res_bad_idle, 0);
        chk($sformatf("v%0d_operand", i), int'(res_opnd), int'(v.instr[10:0]));
        chk($sformatf("v%0d_pc", i), int'(PC), (pc0 + 1) % 2048);
    endtask

    initial begin
        int errs;
        int pc0;
        tbl[0] = '{16'h1805, 5, 0, 2, 0, 2'b01, 1'b0, 1'b0}; // LDI 5
        tbl[1] = '{16'h2003, 5, 3, 2, 0, 2'b10, 1'b0, 1'b0}; // ADD 0x003
        tbl[2] = '{16'h3004, 5, 3, 2, 0, 2'b10, 1'b0, 1'b1}; // SUB 0x004
        tbl[3] = '{16'h0810, 4, 0, 0, 1, 2'b00, 1'b0, 1'b0}; // STO 0x010
        tbl[4] = '{16'h1003, 5, 3, 2, 0, 2'b00, 1'b0, 1'b0}; // LD 0x003
        tbl[5] = '{16'h2807, 5, 0, 2, 0, 2'b10, 1'b1, 1'b0}; // ADDI 7
        tbl[6] = '{16'h3FFF, 5, 0, 2, 0, 2'b10, 1'b1, 1'b1}; // SUBI 0x7FF
        tbl[7] = '{16'hF800, 3, 0, 0, 0, 2'b00, 1'b0, 1'b0}; // NOP (11111)
        tbl[8] = '{16'h4123, 3, 0, 0, 0, 2'b00, 1'b0, 1'b0}; // NOP (01000)

        do_reset();

        for (int i = 0; i < 9; i++) begin
            pc0 = int'(PC);
            chk($sformatf("v%0d_pc_start", i), pc0, i);
            run_instr(tbl[i].instr);
            check_vec(i, tbl[i], pc0);
            chk($sformatf("v%0d_cnt", i), int'(InstrCnt), i + 1);
        end

        // Enable low in FETCH stalls with everything quiet
        Enable = 1'b0;
        Instr = 16'h1805;
        errs = 0;
        for (int k = 0; k < 4; k++) begin
            if (PC != 11'd9 || {WrPC, WrAcc, Clear, RdRam, WrRam, Halted} != 6'd0) errs++;
            step();
        end
        chk("stall_quiet", errs, 0);
        chk("stall_pc", int'(PC), 9);
        Enable = 1'b1;
        run_instr(16'hF800);
        chk("after_stall_cycles", res_cyc, 3);
        chk("after_stall_pc", int'(PC), 10);

        // HLT at PC=7
        do_reset();
        for (int k = 0; k < 7; k++) run_instr(16'hF800);
        chk("pre_hlt_pc", int'(PC), 7);
        run_instr(16'h0000);
        chk("hlt_seen", int'(res_halt), 1);
        chk("hlt_latency", res_cyc, 3);
        chk("hlt_no_wrpc", res_wrpc, 0);
        errs = 0;
        for (int k = 0; k < 6; k++) begin
            Enable = k[0];
            if (!Halted || PC != 11'd7 || InstrCnt != 16'd7 ||
                {WrPC, WrAcc, RdRam, WrRam} != 4'd0) errs++;
            step();
        end
        chk("halt_absorbing", errs, 0);
        do_reset();
        chk("halt_reset_released", int'(Halted), 0);

        // PC wrap from 2047 to 0
        errs = 0;
        for (int k = 0; k < 2047; k++) begin
            run_instr(16'hF800);
            if (res_cyc != 3) errs++;
        end
        chk("nop_run_cycles", errs, 0);
        chk("pc_at_max", int'(PC), 2047);
        chk("cnt_at_max", int'(InstrCnt), 2047);
        run_instr(16'hF800);
        chk("pc_wrap", int'(PC), 0);
        chk("cnt_after_wrap", int'(InstrCnt), 2048);

        // Reset during EXEC_A cuts the write window short
        Instr = 16'h1805;
        step();  // DECODE
        step();  // EXEC_A
        chk("exec_a_wracc", int'(WrAcc), 1);
        Reset = 1'b1;
        step();
        chk("midrst_wracc", int'(WrAcc), 0);
        chk("midrst_pc", int'(PC), 0);
        chk("midrst_cnt", int'(InstrCnt), 0);
        Reset = 1'b0;
        #1;
        chk("midrst_init_clear", int'(Clear), 1);
        chk("midrst_init_wracc", int'(WrAcc), 0);
        step();
        chk("midrst_fetch_clear", int'(Clear), 0);
        run_instr(16'h1805);
        chk("midrst_ldi_cycles", res_cyc, 5);
        chk("midrst_ldi_run", res_run_max, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
